// File: rtl/wake_pkg.sv
// Shared encodings for the wake pipeline: PDM sequencer states and pipeline controller states.
package wake_pkg;

    typedef enum logic [1:0] {
        PDM_OFF    = 2'd0,
        PDM_WARMUP = 2'd1,
        PDM_RUN    = 2'd2,
        PDM_DRAIN  = 2'd3
    } pdm_state_e;

    typedef enum logic [1:0] {
        CTRL_IDLE   = 2'd0,
        CTRL_LISTEN = 2'd1,
        CTRL_WAKE   = 2'd2,
        CTRL_HOLD   = 2'd3
    } ctrl_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pdm_clkdiv.sv
// PDM microphone clock divider: toggles clk_o every PDM_DIV system clocks while running,
// and when stopping lets a high phase finish before parking low.
module pdm_clkdiv #(
    parameter int unsigned PDM_DIV = 25
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run,
    input  logic stop_low,
    output logic clk_o,
    output logic rise_o
);

    localparam int unsigned DW = $clog2(PDM_DIV);

    logic [DW-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt    <= '0;
            clk_o  <= 1'b0;
            rise_o <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            if (!run && !stop_low) begin
                cnt   <= '0;
                clk_o <= 1'b0;
            end else if (run || clk_o) begin
                // While stopping, counting only continues through a high phase.
                if (cnt == DW'(PDM_DIV - 1)) begin
                    cnt    <= '0;
                    clk_o  <= ~clk_o;
                    rise_o <= ~clk_o;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pdm_seq.sv
// PDM microphone power sequencer: clock warm-up, pipeline enable, and drain with timeout.
module pdm_seq
    import wake_pkg::*;
#(
    parameter int unsigned PDM_DIV       = 25,
    parameter int unsigned WARMUP_CYCLES = 1000,
    parameter int unsigned DRAIN_TIMEOUT = 500
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic busy_i,
    output logic pdm_clk_o,
    output logic sample_o,
    output logic pipe_en_o,
    output logic timeout_o
);

    localparam int unsigned PW = $clog2(max_u(WARMUP_CYCLES, DRAIN_TIMEOUT) + 1);

    pdm_state_e    state;
    pdm_state_e    state_nxt;
    logic [PW-1:0] phase;
    logic          div_run;
    logic          div_stop_low;
    logic          div_rise;
    logic          drain_done;
    logic          drain_expired;

    always_comb begin
        drain_done    = !busy_i && !pdm_clk_o;
        drain_expired = (phase == PW'(DRAIN_TIMEOUT - 1));
        state_nxt     = state;
        unique case (state)
            PDM_OFF:    if (en_i) state_nxt = PDM_WARMUP;
            PDM_WARMUP: begin
                if (!en_i)                                 state_nxt = PDM_OFF;
                else if (phase == PW'(WARMUP_CYCLES - 1))  state_nxt = PDM_RUN;
            end
            PDM_RUN:    if (!en_i) state_nxt = PDM_DRAIN;
            PDM_DRAIN:  if (drain_done || drain_expired) state_nxt = PDM_OFF;
            default:    state_nxt = PDM_OFF;
        endcase
        // Divider is cleared on the same edge that enters OFF, so OFF never sees a live clock.
        div_run      = (state == PDM_WARMUP || state == PDM_RUN) && (state_nxt != PDM_OFF);
        div_stop_low = (state == PDM_DRAIN) && (state_nxt == PDM_DRAIN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= PDM_OFF;
            phase     <= '0;
            pipe_en_o <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            pipe_en_o <= (state_nxt == PDM_RUN) || (state_nxt == PDM_DRAIN);
            if (state_nxt != state)
                phase <= '0;
            else if (state == PDM_WARMUP || state == PDM_DRAIN)
                phase <= phase + 1'b1;
            else
                phase <= '0;
            // A busy-driven exit wins over a simultaneous timeout and leaves the flag alone.
            if (state == PDM_OFF && state_nxt == PDM_WARMUP)
                timeout_o <= 1'b0;
            else if (state == PDM_DRAIN && !drain_done && drain_expired)
                timeout_o <= 1'b1;
        end
    end

    pdm_clkdiv #(
        .PDM_DIV (PDM_DIV)
    ) u_div (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .run      (div_run),
        .stop_low (div_stop_low),
        .clk_o    (pdm_clk_o),
        .rise_o   (div_rise)
    );

    assign sample_o = div_rise && (state == PDM_RUN);

endmodule

// File: tb/tb_pdm_seq.sv
// Directed scoreboard bench for pdm_seq with PDM_DIV=2, WARMUP_CYCLES=8, DRAIN_TIMEOUT=16.
module tb_pdm_seq;
    import wake_pkg::*;

    localparam int unsigned DIV = 2;
    localparam int unsigned WU  = 8;
    localparam int unsigned DT  = 16;

    logic clk_i = 1'b0;
    logic rst_i;
    logic en_i;
    logic busy_i;
    logic pdm_clk_o;
    logic sample_o;
    logic pipe_en_o;
    logic timeout_o;

    always #5 clk_i = ~clk_i;

    pdm_seq #(
        .PDM_DIV       (DIV),
        .WARMUP_CYCLES (WU),
        .DRAIN_TIMEOUT (DT)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .busy_i    (busy_i),
        .pdm_clk_o (pdm_clk_o),
        .sample_o  (sample_o),
        .pipe_en_o (pipe_en_o),
        .timeout_o (timeout_o)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            e.tag = "sb_underflow";
            e.val = 'x;
        end else begin
            e = sb.pop_front();
        end
        n_cmp++;
        assert (obs === e.val) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Packed output view: {pdm_clk_o, pipe_en_o, sample_o, timeout_o}
    function automatic logic [31:0] outs();
        return 32'({pdm_clk_o, pipe_en_o, sample_o, timeout_o});
    endfunction

    function automatic logic [31:0] st();
        return 32'(dut.state);
    endfunction

    initial begin
        rst_i  = 1'b1;
        en_i   = 1'b0;
        busy_i = 1'b0;
        repeat (2) step();
        push("reset_outs", 32'h0);
        push("reset_state", 32'(PDM_OFF));
        chk(outs());
        chk(st());
        rst_i = 1'b0;
        step();
        push("idle_state", 32'(PDM_OFF));
        chk(st());

        // Start-up: en_i raised at cycle 0, WARMUP at 1, RUN at WU+1.
        en_i = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            logic pm, pe, sm;
            pm = (((c - 1) / DIV) % 2) == 1;
            pe = c >= int'(WU) + 1;
            sm = pe && pm && (((c - 1) % DIV) == 0);
            push("warm_outs", 32'({pm, pe, sm, 1'b0}));
            push("warm_state", (c <= int'(WU)) ? 32'(PDM_WARMUP) : 32'(PDM_RUN));
        end
        for (int c = 1; c <= 12; c++) begin
            step();
            chk(outs());
            chk(st());
        end

        // Drain with busy held for 5 cycles; clock ends its high phase then parks low.
        en_i   = 1'b0;
        busy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push("drain_outs", 32'(4'b0100));
            push("drain_state", 32'(PDM_DRAIN));
        end
        for (int i = 0; i < 5; i++) begin
            step();
            chk(outs());
            chk(st());
        end
        busy_i = 1'b0;
        push("drain_exit_outs", 32'h0);
        push("drain_exit_state", 32'(PDM_OFF));
        step();
        chk(outs());
        chk(st());

        // Abort warm-up at phase count 4.
        en_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            logic pm;
            pm = (((k - 1) / DIV) % 2) == 1;
            push("abort_warm_outs", 32'({pm, 3'b000}));
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            chk(outs());
        end
        push("abort_phase4", 32'd4);
        chk(32'(dut.phase));
        en_i = 1'b0;
        push("abort_state", 32'(PDM_OFF));
        push("abort_outs", 32'h0);
        push("abort_phase_clr", 32'h0);
        step();
        chk(st());
        chk(outs());
        chk(32'(dut.phase));
        push("abort_hold_outs", 32'h0);
        step();
        chk(outs());

        // Busy stuck high: timeout after DT drain cycles, flag clears on next WARMUP.
        en_i = 1'b1;
        repeat (10) step();
        push("to_run_state", 32'(PDM_RUN));
        chk(st());
        en_i   = 1'b0;
        busy_i = 1'b1;
        for (int i = 0; i < int'(DT); i++) begin
            push("to_drain_state", 32'(PDM_DRAIN));
            push("to_drain_flag", 32'h0);
        end
        for (int i = 0; i < int'(DT); i++) begin
            step();
            chk(st());
            chk(32'(timeout_o));
        end
        push("to_exit_state", 32'(PDM_OFF));
        push("to_exit_outs", 32'(4'b0001));
        step();
        chk(st());
        chk(outs());
        en_i = 1'b1;
        push("to_clear_state", 32'(PDM_WARMUP));
        push("to_clear_outs", 32'h0);
        step();
        chk(st());
        chk(outs());

        // en_i re-asserted mid-drain is ignored; one OFF cycle before WARMUP.
        repeat (9) step();
        push("redo_run_state", 32'(PDM_RUN));
        chk(st());
        en_i = 1'b0;
        step();
        push("redo_drain_state", 32'(PDM_DRAIN));
        chk(st());
        en_i = 1'b1;
        for (int i = 0; i < 4; i++) push("redo_drain_hold", 32'(PDM_DRAIN));
        for (int i = 0; i < 4; i++) begin
            step();
            chk(st());
        end
        push("redo_park_outs", 32'(4'b0100));
        chk(outs());
        busy_i = 1'b0;
        push("redo_off_state", 32'(PDM_OFF));
        push("redo_off_outs", 32'h0);
        push("redo_warm_state", 32'(PDM_WARMUP));
        step();
        chk(st());
        chk(outs());
        step();
        chk(st());

        // Asynchronous reset mid-RUN.
        repeat (9) step();
        push("rst_pre_outs", 32'(4'b0100));
        push("rst_pre_state", 32'(PDM_RUN));
        chk(outs());
        chk(st());
        #2 rst_i = 1'b1;
        #1;
        push("rst_async_outs", 32'h0);
        push("rst_async_state", 32'(PDM_OFF));
        push("rst_async_phase", 32'h0);
        chk(outs());
        chk(st());
        chk(32'(dut.phase));
        step();
        #3 rst_i = 1'b0;
        push("rst_rel_state", 32'(PDM_OFF));
        push("rst_first_edge", 32'(PDM_WARMUP));
        chk(st());
        step();
        chk(st());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
